counting_bloom_filter: RTL and testbench

Parametrised counting Bloom filter for page-address membership tracking, the successor of the single-hash LFSR filter. It keeps `2**LOG_SIZE` saturating counters of `CNT_W` bits and supports `HASH_COUNT` hash indices per page, applied one per cycle. It accepts QUERY, INSERT, DELETE and CLEAR requests over a valid/ready handshake and returns hit, saturation and underflow status on a held response channel. It also reports live occupancy, meaning the number of non-zero counters.

---
 rtl/bloom_pkg.sv | 26 ++
 rtl/bloom_counter_update.sv | 49 ++++
 rtl/counting_bloom_filter.sv | 126 ++++++++++++
 tb/tb_counting_bloom_filter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
// Shared definitions for the counting Bloom filter.
// Op codes, FSM state type and the page-to-index hash helper.
package bloom_pkg;

    localparam logic [1:0] OP_QUERY  = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Page shifted so that hash slice j sits at bit 0; the caller
    // truncates to the index width.
    function automatic logic [63:0] hash_index(
        input logic [63:0] page,
        input int          j,
        input int          stride
    );
        return page >> (j * stride);
    endfunction

endpackage

// File: rtl/bloom_counter_update.sv
// Next-value logic for one saturating counter.
// Ports: op, cnt in; nxt, sat, err, became_nonzero, became_zero out.
module bloom_counter_update
    import bloom_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] nxt,
    output logic             sat,
    output logic             err,
    output logic             became_nonzero,
    output logic             became_zero
);

    logic full;
    logic empty;
    logic ins;
    logic del;

    assign full  = &cnt;
    assign empty = (cnt == '0);
    assign ins   = (op == OP_INSERT);
    assign del   = (op == OP_DELETE);

    // A counter at max is sticky: deleting it would corrupt other keys.
    always_comb begin
        nxt            = cnt;
        sat            = 1'b0;
        err            = 1'b0;
        became_nonzero = 1'b0;
        became_zero    = 1'b0;
        unique case (1'b1)
            (ins && full): sat = 1'b1;
            (ins && !full): begin
                nxt            = cnt + 1'b1;
                became_nonzero = empty;
            end
            (del && empty): err = 1'b1;
            (del && !empty && !full): begin
                nxt         = cnt - 1'b1;
                became_zero = (cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/counting_bloom_filter.sv
// Counting Bloom filter with one hash probe per cycle.
// Ports: CLK, rstb, req_* handshake, rsp_* handshake/status, occupancy.
module counting_bloom_filter
    import bloom_pkg::*;
#(
    parameter int ADDR_W      = 57,
    parameter int PAGE_OFFSET = 12,
    parameter int LOG_SIZE    = 13,
    parameter int HASH_COUNT  = 3,
    parameter int HASH_STRIDE = 15,
    parameter int CNT_W       = 4
) (
    input  logic                CLK,
    input  logic                rstb,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic                rsp_sat,
    output logic                rsp_err,
    output logic [LOG_SIZE:0]   occupancy
);

    localparam int PW   = ADDR_W - PAGE_OFFSET;
    localparam int SIZE = 2 ** LOG_SIZE;
    localparam int JW   = (HASH_COUNT > 1) ? $clog2(HASH_COUNT) : 1;

    if (HASH_COUNT < 1 ||
        (HASH_COUNT - 1) * HASH_STRIDE + LOG_SIZE > PW ||
        PW > 64) begin : g_bad_params
        $fatal(1, "counting_bloom_filter: illegal hash geometry");
    end

    state_t                state;
    logic [1:0]            op_q;
    logic [PW-1:0]         page_q;
    logic [JW-1:0]         j_q;
    logic                  hit_acc;
    logic                  sat_acc;
    logic                  err_acc;
    logic [LOG_SIZE:0]     occ_q;
    logic [CNT_W-1:0]      cnt [SIZE];

    logic [LOG_SIZE-1:0]   idx;
    logic [CNT_W-1:0]      cur;
    logic [CNT_W-1:0]      nxt;
    logic                  u_sat;
    logic                  u_err;
    logic                  u_nz;
    logic                  u_z;
    logic                  last;

    assign idx  = LOG_SIZE'(hash_index(64'(page_q), int'(j_q), HASH_STRIDE));
    assign cur  = cnt[idx];
    assign last = (j_q == JW'(HASH_COUNT - 1));

    bloom_counter_update #(.CNT_W(CNT_W)) u_update (
        .op             (op_q),
        .cnt            (cur),
        .nxt            (nxt),
        .sat            (u_sat),
        .err            (u_err),
        .became_nonzero (u_nz),
        .became_zero    (u_z)
    );

    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            state   <= ST_IDLE;
            op_q    <= OP_QUERY;
            page_q  <= '0;
            j_q     <= '0;
            hit_acc <= 1'b0;
            sat_acc <= 1'b0;
            err_acc <= 1'b0;
            occ_q   <= '0;
            for (int i = 0; i < SIZE; i++) cnt[i] <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        page_q  <= req_addr[ADDR_W-1:PAGE_OFFSET];
                        j_q     <= '0;
                        // hit starts true only for QUERY so other ops report 0
                        hit_acc <= (req_op == OP_QUERY);
                        sat_acc <= 1'b0;
                        err_acc <= 1'b0;
                        if (req_op == OP_CLEAR) begin
                            for (int i = 0; i < SIZE; i++) cnt[i] <= '0;
                            occ_q <= '0;
                            state <= ST_RESP;
                        end else begin
                            state <= ST_PROBE;
                        end
                    end
                end
                ST_PROBE: begin
                    cnt[idx] <= nxt;
                    if (op_q == OP_QUERY) hit_acc <= hit_acc & (cur != '0);
                    sat_acc <= sat_acc | u_sat;
                    err_acc <= err_acc | u_err;
                    if (u_nz) occ_q <= occ_q + 1'b1;
                    else if (u_z) occ_q <= occ_q - 1'b1;
                    if (last) state <= ST_RESP;
                    else j_q <= j_q + 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_hit   = hit_acc;
    assign rsp_sat   = sat_acc;
    assign rsp_err   = err_acc;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_counting_bloom_filter.sv
// Directed bench for counting_bloom_filter using a vector table
// plus hand-written stall, clear and reset-in-probe sequences.
module tb_counting_bloom_filter;
    import bloom_pkg::*;

    localparam logic [56:0] A = 57'h0C0010001000;
    localparam logic [56:0] B = 57'h0;

    logic        CLK = 1'b0;
    logic        rstb = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [56:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_hit;
    logic        rsp_sat;
    logic        rsp_err;
    logic [13:0] occupancy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    counting_bloom_filter dut (
        .CLK       (CLK),
        .rstb      (rstb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_sat   (rsp_sat),
        .rsp_err   (rsp_err),
        .occupancy (occupancy)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [56:0] addr;
        logic        hit;
        logic        sat;
        logic        err;
        logic [13:0] occ;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [1:0] op,
                                input logic [56:0] addr, input logic h,
                                input logic s, input logic e,
                                input logic [13:0] o);
        vec_t v;
        v.name = nm; v.op = op; v.addr = addr;
        v.hit = h; v.sat = s; v.err = e; v.occ = o;
        return v;
    endfunction

    // n counts edges from the accept edge (1) to the first edge after
    // which rsp_valid is seen high.
    task automatic do_req(input vec_t v);
        int n;
        int lat;
        lat = (v.op == OP_CLEAR) ? 1 : 4;
        @(negedge CLK);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({v.name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 50) begin
            @(posedge CLK);
            #1 n++;
        end
        chk({v.name, "_lat"}, 32'(n), 32'(lat));
        chk({v.name, "_hit"}, 32'(rsp_hit), 32'(v.hit));
        chk({v.name, "_sat"}, 32'(rsp_sat), 32'(v.sat));
        chk({v.name, "_err"}, 32'(rsp_err), 32'(v.err));
        chk({v.name, "_occ"}, 32'(occupancy), 32'(v.occ));
        chk({v.name, "_rdy_busy"}, 32'(req_ready), 32'd0);
        @(posedge CLK);
        #1 chk({v.name, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic        s_sat;
        logic [13:0] s_occ;

        tbl.push_back(mk("q_empty",   OP_QUERY,  A, 0, 0, 0, 3'd0));
        tbl.push_back(mk("del_empty", OP_DELETE, A, 0, 0, 1, 3'd0));
        tbl.push_back(mk("ins1",      OP_INSERT, A, 0, 0, 0, 3'd3));
        tbl.push_back(mk("q_hit",     OP_QUERY,  A, 1, 0, 0, 3'd3));
        tbl.push_back(mk("ins2",      OP_INSERT, A, 0, 0, 0, 3'd3));
        tbl.push_back(mk("del1",      OP_DELETE, A, 0, 0, 0, 3'd3));
        tbl.push_back(mk("q_hit2",    OP_QUERY,  A, 1, 0, 0, 3'd3));
        tbl.push_back(mk("del2",      OP_DELETE, A, 0, 0, 0, 3'd0));
        tbl.push_back(mk("q_miss",    OP_QUERY,  A, 0, 0, 0, 3'd0));
        for (int i = 1; i <= 15; i++)
            tbl.push_back(mk($sformatf("ins_sat%0d", i), OP_INSERT, A,
                             0, 0, 0, 3'd3));
        tbl.push_back(mk("ins_sat16", OP_INSERT, A, 0, 1, 0, 3'd3));
        tbl.push_back(mk("del_stick", OP_DELETE, A, 0, 0, 0, 3'd3));
        tbl.push_back(mk("q_b_miss",  OP_QUERY,  B, 0, 0, 0, 3'd3));
        tbl.push_back(mk("ins_b_dup", OP_INSERT, B, 0, 0, 0, 3'd4));
        tbl.push_back(mk("q_b_hit",   OP_QUERY,  B, 1, 0, 0, 3'd4));
        tbl.push_back(mk("clr",       OP_CLEAR,  A, 0, 0, 0, 3'd0));
        tbl.push_back(mk("q_clr",     OP_QUERY,  A, 0, 0, 0, 3'd0));

        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_flags", {29'd0, rsp_hit, rsp_sat, rsp_err}, 32'd0);
        @(negedge CLK);
        rstb = 1'b1;

        foreach (tbl[i]) begin
            do_req(tbl[i]);
            if (tbl[i].name == "del_stick") begin
                chk("stick_c1", 32'(dut.cnt[1]), 32'd15);
                chk("stick_c2", 32'(dut.cnt[2]), 32'd15);
                chk("stick_c3", 32'(dut.cnt[3]), 32'd15);
            end
            if (tbl[i].name == "ins_b_dup")
                chk("dup_c0", 32'(dut.cnt[0]), 32'd3);
            if (tbl[i].name == "del_empty")
                chk("err_c1", 32'(dut.cnt[1]), 32'd0);
        end

        // response held while consumer stalls
        rsp_ready = 1'b0;
        @(negedge CLK);
        req_valid = 1'b1; req_op = OP_INSERT; req_addr = A;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1 chk("stall_valid", 32'(rsp_valid), 32'd1);
        s_sat = rsp_sat;
        s_occ = occupancy;
        chk("stall_sat", 32'(s_sat), 32'd0);
        chk("stall_occ", 32'(s_occ), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("stall_hold_v%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall_hold_r%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("stall_hold_o%0d", k), 32'(occupancy), 32'(s_occ));
            chk($sformatf("stall_hold_s%0d", k), 32'(rsp_sat), 32'(s_sat));
        end
        @(negedge CLK);
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1 chk("stall_release", 32'(req_ready), 32'd1);
        do_req(mk("clr2", OP_CLEAR, A, 0, 0, 0, 3'd0));

        // reset while probing abandons the request
        @(negedge CLK);
        req_valid = 1'b1; req_op = OP_INSERT; req_addr = A;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(posedge CLK);
        #1 chk("probe_partial", 32'(dut.cnt[1]), 32'd1);
        rstb = 1'b0;
        #2;
        chk("rstp_ready", 32'(req_ready), 32'd1);
        chk("rstp_valid", 32'(rsp_valid), 32'd0);
        chk("rstp_occ",   32'(occupancy), 32'd0);
        chk("rstp_c1",    32'(dut.cnt[1]), 32'd0);
        @(negedge CLK);
        rstb = 1'b1;
        repeat (4) @(posedge CLK);
        #1 chk("rstp_no_rsp", 32'(rsp_valid), 32'd0);
        do_req(mk("q_after_rst", OP_QUERY, A, 0, 0, 0, 3'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
